// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with an input FIFO: configurable data width,
// parity, stop bits and baud rate; serial output idles high.
module uart_tx_param #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 overflow
);

  localparam int CPB       = CLK_FREQ / BAUD;
  localparam int STOP_CLKS = STOP_BITS * CPB;
  localparam int CW        = $clog2(STOP_CLKS);
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int BW        = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bidx, bidx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par, par_n;
  logic                 tx_n, done_n;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wptr, rptr;
  logic [DATA_BITS-1:0] head;
  logic                 push, pop;
  logic                 last_bit, last_stop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head       = mem[rptr[AW-1:0]];
  assign push       = tx_start & ~fifo_full;
  assign pop        = (state == IDLE) & ~fifo_empty;
  assign tx_busy    = (state != IDLE) | ~fifo_empty;

  assign last_bit   = (cnt == CW'(CPB - 1));
  assign last_stop  = (cnt == CW'(STOP_CLKS - 1));

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
      overflow <= tx_start & fifo_full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bidx    <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bidx    <= bidx_n;
      shreg   <= shreg_n;
      par     <= par_n;
      tx      <= tx_n;
      tx_done <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    bidx_n  = bidx;
    shreg_n = shreg;
    par_n   = par;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!fifo_empty) begin
          state_n = START;
          shreg_n = head;
          par_n   = (PARITY == 1) ? ~^head : ^head;
        end
      end
      START: begin
        if (last_bit) begin
          state_n = DATA;
          cnt_n   = '0;
          bidx_n  = '0;
        end
      end
      DATA: begin
        if (last_bit) begin
          cnt_n   = '0;
          shreg_n = shreg >> 1;
          if (bidx == BW'(DATA_BITS - 1)) state_n = (PARITY != 0) ? PAR : STOP;
          else bidx_n = bidx + BW'(1);
        end
      end
      PAR: begin
        if (last_bit) begin
          state_n = STOP;
          cnt_n   = '0;
        end
      end
      STOP: begin
        if (last_stop) begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // tx is registered from the next state so the line changes on the same edge as the FSM.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      PAR:     tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: five instances cover 8N1, even/odd parity,
// 7-bit 2-stop framing, and mid-frame reset; line monitors decode and compare frames.
`timescale 1ns/1ps
module tb_uart_tx_param;

  localparam int CPB = 434;

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst4 = 1'b1;
  logic [4:0] st = '0;
  logic [8:0] dat [5];
  logic [4:0] txw, busy, done, full, empty, ovf;

  exp_t sbq [5][$];
  int   pending = 0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_param u0 (.clk(clk), .rst(rst), .tx_start(st[0]), .data(dat[0][7:0]), .tx(txw[0]),
    .tx_busy(busy[0]), .tx_done(done[0]), .fifo_full(full[0]), .fifo_empty(empty[0]), .overflow(ovf[0]));
  uart_tx_param #(.PARITY(2)) u1 (.clk(clk), .rst(rst), .tx_start(st[1]), .data(dat[1][7:0]), .tx(txw[1]),
    .tx_busy(busy[1]), .tx_done(done[1]), .fifo_full(full[1]), .fifo_empty(empty[1]), .overflow(ovf[1]));
  uart_tx_param #(.PARITY(1)) u2 (.clk(clk), .rst(rst), .tx_start(st[2]), .data(dat[2][7:0]), .tx(txw[2]),
    .tx_busy(busy[2]), .tx_done(done[2]), .fifo_full(full[2]), .fifo_empty(empty[2]), .overflow(ovf[2]));
  uart_tx_param #(.DATA_BITS(7), .STOP_BITS(2)) u3 (.clk(clk), .rst(rst), .tx_start(st[3]), .data(dat[3][6:0]),
    .tx(txw[3]), .tx_busy(busy[3]), .tx_done(done[3]), .fifo_full(full[3]), .fifo_empty(empty[3]), .overflow(ovf[3]));
  uart_tx_param u4 (.clk(clk), .rst(rst4), .tx_start(st[4]), .data(dat[4][7:0]), .tx(txw[4]),
    .tx_busy(busy[4]), .tx_done(done[4]), .fifo_full(full[4]), .fifo_empty(empty[4]), .overflow(ovf[4]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one write; when track is set the hand-computed line frame is queued.
  task automatic push(input int ch, input logic [8:0] v, input bit track,
                      input logic [11:0] bits, input int nbits, input int gap);
    exp_t e;
    if (track) begin
      e.bits = bits; e.nbits = nbits; e.gap = gap;
      sbq[ch].push_back(e);
      pending++;
    end
    dat[ch] = v;
    st[ch]  = 1'b1;
    @(posedge clk); #1;
    st[ch]  = 1'b0;
  endtask

  task automatic wait_done(input int ch, input int limit, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      seen = done[ch];
    end
  endtask

  task automatic mon(input int ch, input int cpb);
    exp_t        e;
    logic [11:0] got;
    int          start;
    int          prev_done;
    bit          seen;
    prev_done = -1;
    forever begin
      @(negedge clk);
      if (txw[ch] == 1'b0) begin
        start = cyc;
        if (sbq[ch].size() == 0) begin
          chk($sformatf("ch%0d unexpected frame", ch), 1, 0);
          repeat (cpb * 13) @(negedge clk);
        end else begin
          e = sbq[ch].pop_front();
          if (e.gap >= 0 && prev_done >= 0)
            chk($sformatf("ch%0d idle gap", ch), start - prev_done, e.gap);
          got = '0;
          repeat (cpb / 2) @(negedge clk);
          for (int i = 0; i < e.nbits; i++) begin
            got[i] = txw[ch];
            if (i < e.nbits - 1) repeat (cpb) @(negedge clk);
          end
          chk($sformatf("ch%0d frame bits", ch), got, e.bits);
          wait_done(ch, 2 * cpb, seen);
          chk($sformatf("ch%0d done timing", ch), seen ? cyc - start : -1, e.nbits * cpb);
          prev_done = cyc;
          pending--;
        end
      end
    end
  endtask

  task automatic run_u0();
    bit   seen;
    logic exp_full [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    push(0, 9'hA5, 1'b1, 12'b001101001010, 10, -1);
    chk("u0 empty after write", empty[0], 0);
    chk("u0 tx idle after write", txw[0], 1);
    @(posedge clk); #1;
    chk("u0 tx start 2 edges", txw[0], 0);
    chk("u0 busy in frame", busy[0], 1);
    wait_done(0, 5000, seen);
    chk("u0 done seen", seen, 1);
    chk("u0 busy falls with done", busy[0], 0);
    repeat (5) @(posedge clk); #1;
    // 1 pop happens on the second write edge, so the fifth write fills the FIFO
    push(0, 9'h11, 1'b1, 12'b001000100010, 10, -1);
    chk("u0 full after push1", full[0], exp_full[0]);
    push(0, 9'h22, 1'b1, 12'b001001000100, 10, 1);
    chk("u0 full after push2", full[0], exp_full[1]);
    push(0, 9'h33, 1'b1, 12'b001001100110, 10, 1);
    chk("u0 full after push3", full[0], exp_full[2]);
    push(0, 9'h44, 1'b1, 12'b001010001000, 10, 1);
    chk("u0 full after push4", full[0], exp_full[3]);
    push(0, 9'h55, 1'b1, 12'b001010101010, 10, 1);
    chk("u0 full after push5", full[0], exp_full[4]);
    chk("u0 no overflow on push5", ovf[0], 0);
    wait_done(0, 5000, seen);
    chk("u0 done of 0x11", seen, 1);
    chk("u0 full before pop", full[0], 1);
    dat[0] = 9'h66;
    st[0]  = 1'b1;
    @(posedge clk); #1;
    st[0]  = 1'b0;
    chk("u0 overflow pulse", ovf[0], 1);
    chk("u0 count dropped", full[0], 0);
    chk("u0 not empty", empty[0], 0);
    @(posedge clk); #1;
    chk("u0 overflow one cycle", ovf[0], 0);
  endtask

  task automatic run_u4();
    push(4, 9'hA5, 1'b0, '0, 0, -1);
    repeat (CPB + 4 * CPB) @(posedge clk);
    #1;
    chk("u4 mid-frame busy", busy[4], 1);
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    chk("u4 tx after reset", txw[4], 1);
    chk("u4 empty after reset", empty[4], 1);
    chk("u4 busy after reset", busy[4], 0);
    repeat (CPB) @(posedge clk);
    #1;
    chk("u4 line stays idle", txw[4], 1);
    fork mon(4, CPB); join_none
    push(4, 9'h3C, 1'b1, 12'b001001111000, 10, -1);
  endtask

  initial begin
    bit ok;
    foreach (dat[i]) dat[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst  = 1'b0;
    rst4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("ch%0d reset tx", i), txw[i], 1);
      chk($sformatf("ch%0d reset busy", i), busy[i], 0);
      chk($sformatf("ch%0d reset done", i), done[i], 0);
      chk($sformatf("ch%0d reset full", i), full[i], 0);
      chk($sformatf("ch%0d reset empty", i), empty[i], 1);
      chk($sformatf("ch%0d reset overflow", i), ovf[i], 0);
    end
    fork
      mon(0, CPB);
      mon(1, CPB);
      mon(2, CPB);
      mon(3, CPB);
    join_none
    fork
      run_u0();
      begin
        push(1, 9'h07, 1'b1, 12'b011000001110, 11, -1);
        push(1, 9'hA5, 1'b1, 12'b010101001010, 11, 1);
      end
      push(2, 9'h07, 1'b1, 12'b010000001110, 11, -1);
      push(3, 9'h55, 1'b1, 12'b001110101010, 10, -1);
      run_u4();
    join
    ok = 1'b0;
    for (int k = 0; k < 30000 && !ok; k++) begin
      @(posedge clk);
      ok = (pending == 0);
    end
    chk("frames outstanding", pending, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
